// File: rtl/frame_cfg_pkg.sv
// Shared types for the frame-synchronous filter configuration sequencer: state, enable bit map, demo presets.
// Pure declarations, no latency; no flow control involved.
package frame_cfg_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    DEMO   = 1'b1
  } state_t;

  localparam int EN_CARTOON = 2;
  localparam int EN_GRAY    = 3;
  localparam int EN_GSC     = 4;
  localparam int EN_EDGE    = 5;

  localparam int PRESET_COUNT = 4;

  typedef struct packed {
    logic       en_edge;
    logic       en_gsc;
    logic       en_gray;
    logic       en_cartoon;
    logic [3:0] clr;
    logic [3:0] gauss;
    logic [3:0] edge_gauss;
  } preset_t;

  localparam preset_t PRESET_ROM [PRESET_COUNT] = '{
    '{en_edge: 1'b0, en_gsc: 1'b0, en_gray: 1'b0, en_cartoon: 1'b0, clr: 4'd0, gauss: 4'd0, edge_gauss: 4'd1},
    '{en_edge: 1'b1, en_gsc: 1'b0, en_gray: 1'b0, en_cartoon: 1'b0, clr: 4'd0, gauss: 4'd0, edge_gauss: 4'd2},
    '{en_edge: 1'b1, en_gsc: 1'b0, en_gray: 1'b0, en_cartoon: 1'b1, clr: 4'd0, gauss: 4'd1, edge_gauss: 4'd1},
    '{en_edge: 1'b0, en_gsc: 1'b0, en_gray: 1'b1, en_cartoon: 1'b0, clr: 4'd0, gauss: 4'd3, edge_gauss: 4'd0}
  };

  // Spread the four enable flags onto the 32-bit filter enable word.
  function automatic logic [31:0] build_en(input preset_t cfg);
    logic [31:0] word;
    word             = '0;
    word[EN_EDGE]    = cfg.en_edge;
    word[EN_GSC]     = cfg.en_gsc;
    word[EN_GRAY]    = cfg.en_gray;
    word[EN_CARTOON] = cfg.en_cartoon;
    return word;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key debouncer: 2-flop sync, accept level after DEBOUNCE_CYC stable cycles, one-cycle press pulse on 1->0.
// Latency 2 + DEBOUNCE_CYC cycles from raw edge to press; no backpressure, press is fire-and-forget.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          accepted;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1  <= 1'b1;
      sync_q2  <= 1'b1;
      accepted <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (sync_q2 == accepted) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt      <= '0;
        accepted <= sync_q2;
        press    <= accepted;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_cfg_sequencer.sv
// Frame-boundary filter configuration: debounced brightness/contrast steps, switch config, auto-demo presets.
// All outputs change exactly 1 cycle after frame_start; no backpressure, step pulses are single-cycle.
module frame_cfg_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 65536,
  parameter int DEMO_FRAMES  = 120,
  parameter int NUM_PRESETS  = PRESET_COUNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [3:0]  KEY,
  input  logic [8:0]  sw,
  output logic [31:0] en,
  output logic [3:0]  clr_sel,
  output logic [3:0]  gauss_sel,
  output logic [3:0]  edge_gauss_sel,
  output logic        binc,
  output logic        bdec,
  output logic        cinc,
  output logic        cdec,
  output logic        demo_active,
  output logic [1:0]  preset_idx
);

  localparam int            FW         = (DEMO_FRAMES > 1) ? $clog2(DEMO_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(DEMO_FRAMES - 1);
  localparam logic [1:0]    IDX_LAST   = 2'(NUM_PRESETS - 1);

  logic [3:0]    press;
  logic [8:0]    sw_q1;
  logic [8:0]    sw_q2;
  state_t        state;
  logic [FW-1:0] frame_cnt;
  logic [3:0]    pend;
  logic [1:0]    idx_adv;
  preset_t       manual_cfg;
  preset_t       cfg_q;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key_debounce (
      .clk    (clk),
      .rst    (rst),
      .key_raw(KEY[k]),
      .press  (press[k])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_q1 <= '0;
      sw_q2 <= '0;
    end else begin
      sw_q1 <= sw;
      sw_q2 <= sw_q1;
    end
  end

  always_comb begin
    manual_cfg            = '0;
    manual_cfg.en_edge    = sw_q2[0];
    manual_cfg.en_cartoon = sw_q2[1];
    manual_cfg.en_gray    = sw_q2[2];
    manual_cfg.en_gsc     = sw_q2[3];
    manual_cfg.gauss      = {2'b00, sw_q2[5:4]};
    manual_cfg.clr        = {2'b00, sw_q2[7:6]};
    manual_cfg.edge_gauss = 4'd1;
  end

  assign idx_adv = (preset_idx == IDX_LAST) ? 2'd0 : preset_idx + 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= MANUAL;
      frame_cnt   <= '0;
      pend        <= '0;
      cfg_q       <= '0;
      preset_idx  <= '0;
      demo_active <= 1'b0;
      binc        <= 1'b0;
      bdec        <= 1'b0;
      cinc        <= 1'b0;
      cdec        <= 1'b0;
    end else begin
      binc <= 1'b0;
      bdec <= 1'b0;
      cinc <= 1'b0;
      cdec <= 1'b0;

      // A press landing on the boundary cycle is kept for the following frame.
      if (state == DEMO) begin
        pend <= '0;
      end else if (frame_start) begin
        pend <= press;
      end else begin
        pend <= pend | press;
      end

      if (frame_start) begin
        demo_active <= sw_q2[8];
        unique case (state)
          MANUAL: begin
            // Opposing requests for the same control cancel each other.
            binc <= pend[0] & ~pend[1];
            bdec <= pend[1] & ~pend[0];
            cinc <= pend[2] & ~pend[3];
            cdec <= pend[3] & ~pend[2];
            if (sw_q2[8]) begin
              state      <= DEMO;
              frame_cnt  <= '0;
              preset_idx <= '0;
              cfg_q      <= PRESET_ROM[0];
            end else begin
              cfg_q <= manual_cfg;
            end
          end
          DEMO: begin
            if (!sw_q2[8]) begin
              state      <= MANUAL;
              frame_cnt  <= '0;
              preset_idx <= '0;
              cfg_q      <= manual_cfg;
            end else if (frame_cnt == FRAME_LAST) begin
              frame_cnt  <= '0;
              preset_idx <= idx_adv;
              cfg_q      <= PRESET_ROM[idx_adv];
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
              cfg_q     <= PRESET_ROM[preset_idx];
            end
          end
          default: state <= MANUAL;
        endcase
      end
    end
  end

  assign en             = build_en(cfg_q);
  assign clr_sel        = cfg_q.clr;
  assign gauss_sel      = cfg_q.gauss;
  assign edge_gauss_sel = cfg_q.edge_gauss;

endmodule

// File: tb/tb_frame_cfg_sequencer.sv
// Randomized bench for frame_cfg_sequencer against a frame-level reference model.
// Directed phases cover reset, bounce/merge, cancel, boundary coincidence, mid-frame switches, demo cycling.
module tb_frame_cfg_sequencer;

  localparam int DEB = 16;
  localparam int DF  = 2;
  localparam int NP  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic [3:0]  KEY = 4'hF;
  logic [8:0]  sw = '0;
  logic [31:0] en;
  logic [3:0]  clr_sel, gauss_sel, edge_gauss_sel;
  logic        binc, bdec, cinc, cdec, demo_active;
  logic [1:0]  preset_idx;

  frame_cfg_sequencer #(
    .DEBOUNCE_CYC(DEB),
    .DEMO_FRAMES (DF),
    .NUM_PRESETS (NP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .KEY           (KEY),
    .sw            (sw),
    .en            (en),
    .clr_sel       (clr_sel),
    .gauss_sel     (gauss_sel),
    .edge_gauss_sel(edge_gauss_sel),
    .binc          (binc),
    .bdec          (bdec),
    .cinc          (cinc),
    .cdec          (cdec),
    .demo_active   (demo_active),
    .preset_idx    (preset_idx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: synchroniser delay lines, accepted key levels, pending steps, demo frame count.
  bit [3:0]  m_key1, m_key2, m_acc, m_press, m_pend, m_pulse;
  int        m_run [4];
  bit [8:0]  m_sw1, m_sw2;
  bit        m_demo, m_dact;
  int        m_seen;
  bit [31:0] m_en;
  bit [3:0]  m_clr, m_gauss, m_eg;
  bit [1:0]  m_idx;
  int        pcount [4];

  logic [31:0] P_EN    [4] = '{32'h0, 32'h20, 32'h24, 32'h08};
  int          P_GAUSS [4] = '{0, 0, 1, 3};
  int          P_EG    [4] = '{1, 2, 1, 0};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_key1 = 4'hF; m_key2 = 4'hF; m_acc = 4'hF; m_press = '0; m_pend = '0; m_pulse = '0;
    for (int k = 0; k < 4; k++) m_run[k] = 0;
    m_sw1 = '0; m_sw2 = '0;
    m_demo = 1'b0; m_dact = 1'b0; m_seen = 0;
    m_en = '0; m_clr = '0; m_gauss = '0; m_eg = '0; m_idx = '0;
  endtask

  task automatic model_edge();
    bit [3:0] new_press;
    bit [3:0] old_press;
    bit [8:0] swv;
    int       p;
    old_press = m_press;
    swv       = m_sw2;
    for (int k = 0; k < 4; k++) begin
      new_press[k] = 1'b0;
      if (m_key2[k] != m_acc[k]) begin
        m_run[k]++;
        if (m_run[k] == DEB) begin
          new_press[k] = m_acc[k];
          m_acc[k]     = m_key2[k];
          m_run[k]     = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_key2 = m_key1; m_key1 = KEY;
    m_sw2  = m_sw1;  m_sw1  = sw;
    m_press = new_press;

    m_pulse = '0;
    if (frame_start && !m_demo)
      m_pulse = {m_pend[0] & ~m_pend[1], m_pend[1] & ~m_pend[0],
                 m_pend[2] & ~m_pend[3], m_pend[3] & ~m_pend[2]};
    if (m_demo)           m_pend = '0;
    else if (frame_start) m_pend = old_press;
    else                  m_pend = m_pend | old_press;

    if (frame_start) begin
      if (!m_demo) begin
        if (swv[8]) begin m_demo = 1'b1; m_seen = 0; end
      end else if (!swv[8]) begin
        m_demo = 1'b0;
      end else begin
        m_seen++;
      end
      if (m_demo) begin
        p       = (m_seen / DF) % NP;
        m_en    = P_EN[p];
        m_clr   = 4'd0;
        m_gauss = 4'(P_GAUSS[p]);
        m_eg    = 4'(P_EG[p]);
        m_idx   = 2'(p);
      end else begin
        m_en    = (32'(swv[0]) << 5) | (32'(swv[1]) << 2) | (32'(swv[2]) << 3) | (32'(swv[3]) << 4);
        m_clr   = {2'b00, swv[7:6]};
        m_gauss = {2'b00, swv[5:4]};
        m_eg    = 4'd1;
        m_idx   = 2'd0;
      end
      m_dact = m_demo;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    #1;
    check_val("en", en, m_en);
    check_val("clr_sel", 32'(clr_sel), 32'(m_clr));
    check_val("gauss_sel", 32'(gauss_sel), 32'(m_gauss));
    check_val("edge_gauss_sel", 32'(edge_gauss_sel), 32'(m_eg));
    check_val("pulses", 32'({binc, bdec, cinc, cdec}), 32'(m_pulse));
    check_val("demo_active", 32'(demo_active), 32'(m_dact));
    check_val("preset_idx", 32'(preset_idx), 32'(m_idx));
    if (binc) pcount[0]++;
    if (bdec) pcount[1]++;
    if (cinc) pcount[2]++;
    if (cdec) pcount[3]++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 4; k++) pcount[k] = 0;
  endtask

  int       seg_left [4];
  bit       seg_lvl  [4];
  int       frame_left;
  int       demo_seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    model_reset();
    clear_counts();
    run(3);
    rst = 1'b1;
    sw  = {1'b0, 8'($urandom)};
    run(5);
    frame();
    run(10);

    // Asynchronous reset in the middle of a frame.
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_val("rst_en", en, 32'h0);
    check_val("rst_sel", 32'({clr_sel, gauss_sel, edge_gauss_sel}), 32'h0);
    check_val("rst_misc", 32'({binc, bdec, cinc, cdec, demo_active, preset_idx}), 32'h0);
    sw = 9'h00F;
    run(2);
    rst = 1'b1;
    run(3);
    check_val("pre_boundary_en", en, 32'h0);
    frame();
    check_val("boundary_en", en, 32'h3C);
    check_val("boundary_eg", 32'(edge_gauss_sel), 32'd1);

    // Bounce then three held presses merge into one step.
    clear_counts();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        KEY[0] = 1'($urandom_range(0, 1));
        cycle();
      end
      KEY[0] = 1'b0; run(20);
      KEY[0] = 1'b1; run(20);
    end
    check_val("merge_early", 32'(pcount[0]), 32'd0);
    frame();
    check_val("merge_edge", 32'(binc), 32'd1);
    run(3);
    check_val("merge_binc", 32'(pcount[0]), 32'd1);

    clear_counts();
    KEY[0] = 1'b0; run(12);
    KEY[0] = 1'b1; run(20);
    frame(); run(3);
    check_val("short_hold", 32'(pcount[0]), 32'd0);

    // Opposing contrast requests cancel.
    clear_counts();
    KEY[2] = 1'b0; KEY[3] = 1'b0; run(20);
    KEY = 4'hF; run(20);
    frame(); run(3);
    frame(); run(3);
    check_val("cancel", 32'(pcount[2] + pcount[3]), 32'd0);

    // Press event on the frame_start cycle waits for the next boundary.
    clear_counts();
    KEY[1] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (m_press[1]) break;
    end
    frame(); run(3);
    check_val("coinc_first", 32'(pcount[1]), 32'd0);
    KEY[1] = 1'b1; run(20);
    frame(); run(3);
    check_val("coinc_second", 32'(pcount[1]), 32'd1);

    // Mid-frame switch change.
    sw = 9'h000;
    run(3); frame(); run(5);
    sw = 9'h020;
    run(10);
    check_val("midframe_gauss", 32'(gauss_sel), 32'd0);
    frame();
    check_val("boundary_gauss", 32'(gauss_sel), 32'd2);

    // Demo cycling with key presses ignored.
    clear_counts();
    sw = 9'h100 | 9'($urandom_range(0, 255));
    run(4);
    for (int f = 0; f < 9; f++) begin
      frame();
      check_val("demo_idx", 32'(preset_idx), 32'(demo_seq[f]));
      if (demo_seq[f] == 3) check_val("p3_gauss", 32'(gauss_sel), 32'd3);
      KEY = 4'b1010; run(20);
      KEY = 4'hF;    run(20);
    end
    check_val("demo_pulses", 32'(pcount[0] + pcount[1] + pcount[2] + pcount[3]), 32'd0);
    sw = 9'h000;
    run(4);
    frame();
    check_val("demo_exit", 32'(demo_active), 32'd0);
    check_val("demo_exit_eg", 32'(edge_gauss_sel), 32'd1);

    // Random traffic.
    for (int k = 0; k < 4; k++) begin seg_left[k] = 0; seg_lvl[k] = 1'b1; end
    frame_left = 20;
    for (int c = 0; c < 5000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (seg_left[k] == 0) begin
          if ($urandom_range(0, 1) == 1) seg_left[k] = int'($urandom_range(1, 3));
          else                           seg_left[k] = int'($urandom_range(18, 40));
          seg_lvl[k] = 1'($urandom_range(0, 1));
        end
        KEY[k] = seg_lvl[k];
        seg_left[k]--;
      end
      if (frame_left == 0) begin
        frame_start = 1'b1;
        frame_left  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(8, 60));
      end else begin
        frame_start = (m_press != 4'h0) && ($urandom_range(0, 3) == 0);
        frame_left--;
      end
      if ($urandom_range(0, 39) == 0)  sw[7:0] = 8'($urandom);
      if ($urandom_range(0, 299) == 0) sw[8]   = ~sw[8];
      cycle();
    end
    frame_start = 1'b0;
    KEY = 4'hF;
    run(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
